hazard_forward_unit: RTL and testbench

//  Tracks destination registers of in-flight instructions across ID/EX, EX/MEM and MEM/WB.

---
 rtl/hazard_forward_unit.sv | 103 ++++++++++
 tb/tb_hazard_forward_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_forward_unit.sv
// Hazard/forwarding unit: tracks in-flight destination registers through ID/EX, EX/MEM, MEM/WB,
// drives EX operand forward selects and a one-cycle load-use stall with a saturating stall counter.

module hazard_fwd_lane #(
  parameter int REG_AW = 4
) (
  input  logic              ex_vld,
  input  logic [REG_AW-1:0] rs,
  input  logic              mem_live,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_live,
  input  logic [REG_AW-1:0] wb_rd,
  output logic              fwd,
  output logic              sel
);
  logic mem_hit, wb_hit;

  assign mem_hit = mem_live & (mem_rd == rs);
  assign wb_hit  = wb_live & (wb_rd == rs);
  // EX/MEM holds the youngest value, so it shadows a MEM/WB match
  assign fwd     = ex_vld & (mem_hit | wb_hit);
  assign sel     = ex_vld & ~mem_hit & wb_hit;
endmodule

module hazard_forward_unit #(
  parameter int REG_AW     = 4,
  parameter int ZERO_CONST = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              idValid,
  input  logic [REG_AW-1:0] idRs1,
  input  logic [REG_AW-1:0] idRs2,
  input  logic [REG_AW-1:0] idRd,
  input  logic              idRegWrite,
  input  logic              idMemRead,
  input  logic              flush,
  output logic              Fa,
  output logic              FwdSelA,
  output logic              Fb,
  output logic              FwdSelB,
  output logic              stall,
  output logic [CNT_W-1:0]  stallCount
);
  localparam int STAGES  = 2;  // index 0 = ID/EX, 1 = EX/MEM, 2 = MEM/WB
  localparam int NUM_OPS = 2;

  logic [STAGES:0]                  vld_pipe;
  logic [STAGES:0]                  rw_pipe;
  logic [STAGES:0]                  live;
  logic [STAGES:0][REG_AW-1:0]      rd_pipe;
  logic [NUM_OPS-1:0][REG_AW-1:0]   ex_rs;
  logic                             ex_mr;
  logic [NUM_OPS-1:0]               fwd, sel;
  logic                             ex_load;
  logic [CNT_W-1:0]                 cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      cnt      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], ex_load};
      if (stall && cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  // Payload is captured unconditionally; the valid bits alone decide whether an entry counts.
  always_ff @(posedge clk) begin
    rd_pipe <= {rd_pipe[STAGES-1:0], idRd};
    rw_pipe <= {rw_pipe[STAGES-1:0], idRegWrite};
    ex_rs   <= {idRs2, idRs1};
    ex_mr   <= idMemRead;
  end

  for (genvar s = 0; s <= STAGES; s++) begin : g_live
    assign live[s] = vld_pipe[s] & rw_pipe[s] & ((rd_pipe[s] != '0) | (ZERO_CONST == 0));
  end

  assign stall   = idValid & ~flush & live[0] & ex_mr &
                   ((rd_pipe[0] == idRs1) | (rd_pipe[0] == idRs2));
  assign ex_load = idValid & ~stall & ~flush;

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    hazard_fwd_lane #(.REG_AW(REG_AW)) u_lane (
      .ex_vld  (vld_pipe[0]),
      .rs      (ex_rs[i]),
      .mem_live(live[1]),
      .mem_rd  (rd_pipe[1]),
      .wb_live (live[2]),
      .wb_rd   (rd_pipe[2]),
      .fwd     (fwd[i]),
      .sel     (sel[i])
    );
  end

  assign Fa         = fwd[0];
  assign FwdSelA    = sel[0];
  assign Fb         = fwd[1];
  assign FwdSelB    = sel[1];
  assign stallCount = cnt;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: directed scenarios plus randomized traffic against an
// instruction-level model of the three in-flight slots.

module tb_hazard_forward_unit;
  logic       clk = 0, rst = 1;
  logic       idValid = 0, idRegWrite = 0, idMemRead = 0, flush = 0;
  logic [3:0] idRs1 = 0, idRs2 = 0, idRd = 0;
  logic       Fa, FwdSelA, Fb, FwdSelB, stall;
  logic [15:0] stallCount;
  logic       sFa, sFwdSelA, sFb, sFwdSelB, sStall;
  logic [1:0] sCount;
  int chk_cnt = 0, pass_cnt = 0;

  always #5 clk = ~clk;

  hazard_forward_unit dut (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .flush(flush),
    .Fa(Fa), .FwdSelA(FwdSelA), .Fb(Fb), .FwdSelB(FwdSelB), .stall(stall), .stallCount(stallCount)
  );

  hazard_forward_unit #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .idValid(idValid), .idRs1(idRs1), .idRs2(idRs2), .idRd(idRd),
    .idRegWrite(idRegWrite), .idMemRead(idMemRead), .flush(flush),
    .Fa(sFa), .FwdSelA(sFwdSelA), .Fb(sFb), .FwdSelB(sFwdSelB), .stall(sStall), .stallCount(sCount)
  );

  // Reference model: one instruction record per in-flight slot
  typedef struct packed {
    logic       v;
    logic [3:0] rs1, rs2, rd;
    logic       rw, mr;
  } ins_t;

  ins_t m_ex = '0, m_mem = '0, m_wb = '0;
  int   m_cnt = 0, m_scnt = 0;
  bit   m_st;

  function automatic bit m_live(ins_t i);
    return i.v && i.rw && i.rd != 4'd0;
  endfunction

  function automatic logic [1:0] m_fwd(logic [3:0] rs);
    if (!m_ex.v) return 2'b00;
    if (m_live(m_mem) && m_mem.rd == rs) return 2'b10;
    if (m_live(m_wb) && m_wb.rd == rs) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit m_stall();
    return idValid && !flush && m_live(m_ex) && m_ex.mr && (m_ex.rd == idRs1 || m_ex.rd == idRs2);
  endfunction

  function automatic logic [4:0] m_out();
    return {m_fwd(m_ex.rs1), m_fwd(m_ex.rs2), m_stall()};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0; m_cnt = 0; m_scnt = 0;
    end else begin
      m_st = m_stall();
      if (m_st) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_scnt < 3) m_scnt++;
      end
      m_wb  = m_mem;
      m_mem = m_ex;
      if (idValid && !flush && !m_st) m_ex = '{1'b1, idRs1, idRs2, idRd, idRegWrite, idMemRead};
      else m_ex = '0;
    end
  end

  task automatic drive(input bit v, input logic [3:0] r1, r2, rd, input bit rw, mr, fl, input bit r = 0);
    @(negedge clk);
    rst = r; idValid = v; idRs1 = r1; idRs2 = r2; idRd = rd;
    idRegWrite = rw; idMemRead = mr; flush = fl;
    #1;
  endtask

  task automatic nops(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    #1;
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b0) $display("FAIL reset_outs: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    chk_cnt++;
    if (stallCount !== 16'd0 || sCount !== 2'd0) $display("FAIL reset_cnt: got %0d/%0d want 0/0", stallCount, sCount);
    else pass_cnt++;
    rst = 0;
    // reset mid-operation must drop producers already in flight
    drive(1, 1, 2, 3, 1, 0, 0);
    drive(1, 1, 2, 3, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(1, 3, 3, 4, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b0) $display("FAIL reset_midop: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
  endtask

  task automatic test_fwd_exmem();
    nops(3);
    drive(1, 1, 2, 3, 1, 0, 0);
    drive(1, 3, 4, 5, 1, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b0) $display("FAIL exmem_pre: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b10000) $display("FAIL exmem_fwd: got %b want 10000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
  endtask

  task automatic test_fwd_memwb();
    nops(3);
    drive(1, 1, 2, 3, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(1, 2, 3, 6, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b00110) $display("FAIL memwb_fwd: got %b want 00110", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    nops(3);
    drive(1, 1, 2, 3, 1, 0, 0);
    drive(1, 1, 2, 3, 1, 0, 0);
    drive(1, 3, 3, 8, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b10100) $display("FAIL youngest_wins: got %b want 10100", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    nops(3);
    drive(1, 1, 2, 7, 1, 1, 0);
    drive(1, 7, 2, 1, 1, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b00001) $display("FAIL lu_stall: got %b want 00001", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    drive(1, 7, 2, 1, 1, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b00000) $display("FAIL lu_bubble: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    chk_cnt++;
    if (stallCount !== 16'd1) $display("FAIL lu_count: got %0d want 1", stallCount);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b11000) $display("FAIL lu_fwd_wb: got %b want 11000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    nops(3);
    drive(1, 1, 2, 0, 1, 0, 0);
    drive(1, 0, 0, 5, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b0) $display("FAIL zero_fwd: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    drive(1, 1, 2, 0, 1, 1, 0);
    drive(1, 0, 0, 5, 1, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b0) $display("FAIL zero_stall: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
  endtask

  task automatic test_flush();
    nops(3);
    drive(1, 1, 2, 7, 1, 1, 0);
    drive(1, 7, 7, 1, 1, 0, 1);
    chk_cnt++;
    if (stall !== 1'b0) $display("FAIL flush_nostall: got %b want 0", stall);
    else pass_cnt++;
    drive(0, 0, 0, 0, 0, 0, 0);
    chk_cnt++;
    if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== 5'b0) $display("FAIL flush_bubble: got %b want 00000", {Fa, FwdSelA, Fb, FwdSelB, stall});
    else pass_cnt++;
    chk_cnt++;
    if (stallCount !== 16'd1) $display("FAIL flush_count: got %0d want 1", stallCount);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    logic [1:0] want;
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 1; k <= 5; k++) begin
      drive(1, 1, 2, 7, 1, 1, 0);
      drive(1, 7, 2, 1, 1, 0, 0);
      drive(1, 7, 2, 1, 1, 0, 0);
      want = (k >= 3) ? 2'd3 : 2'(k);
      chk_cnt++;
      if (sCount !== want) $display("FAIL sat_count%0d: got %0d want %0d", k, sCount, want);
      else pass_cnt++;
    end
    chk_cnt++;
    if (stallCount !== 16'd5) $display("FAIL sat_wide: got %0d want 5", stallCount);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [4:0] exp_o;
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
            4'($urandom_range(0, 3)), $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 3,
            $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0);
      exp_o = m_out();
      chk_cnt++;
      if ({Fa, FwdSelA, Fb, FwdSelB, stall} !== exp_o || {sFa, sFwdSelA, sFb, sFwdSelB, sStall} !== exp_o)
        $display("FAIL rand_outs@%0d: got %b/%b want %b", n, {Fa, FwdSelA, Fb, FwdSelB, stall},
                 {sFa, sFwdSelA, sFb, sFwdSelB, sStall}, exp_o);
      else pass_cnt++;
      chk_cnt++;
      if (stallCount !== 16'(m_cnt) || sCount !== 2'(m_scnt))
        $display("FAIL rand_cnt@%0d: got %0d/%0d want %0d/%0d", n, stallCount, sCount, m_cnt, m_scnt);
      else pass_cnt++;
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
